// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default baud divisor and frame shape.
// Also provides the line-level helper used by the transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE  = 3'd0,
    UART_START = 3'd1,
    UART_DATA  = 3'd2,
    UART_STOP  = 3'd3
  } uart_state_e;

  localparam int UART_CLKS_PER_BIT_115200 = 434;
  localparam int UART_DATA_BITS           = 8;
  localparam int UART_STOP_BITS           = 1;

  // Serial line level for a given state; data states drive the current shift LSB.
  function automatic logic uart_line_level(input uart_state_e st, input logic data_bit);
    logic lvl;
    case (st)
      UART_IDLE:  lvl = 1'b1;
      UART_START: lvl = 1'b0;
      UART_DATA:  lvl = data_bit;
      UART_STOP:  lvl = 1'b1;
      default:    lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rd_data presents the head entry whenever the FIFO is not empty.
// Writes while full are dropped and reported by a registered one-cycle overflow pulse.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             overflow_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // full is judged on the registered count, i.e. before any pop in the same cycle
  assign full     = (count_r == DEPTH_C);
  assign empty    = (count_r == {CW{1'b0}});
  assign count    = count_r;
  assign overflow = overflow_r;
  assign rd_data  = mem_r[rd_ptr_r];
  assign wr_ok_s  = wr_en & ~full;
  assign rd_ok_s  = rd_en & ~empty;

  // Storage array and write pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
    end else if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
      wr_ptr_r        <= wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer, occupancy and overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= wr_en & full;
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a show-ahead FIFO feeds an FSM that serialises bytes LSB first.
// Frames are chained with no idle gap while bytes remain queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200,
  parameter int DEPTH        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   tx,
  output logic                   active,
  output logic                   done,
  output logic [2:0]             tx_state
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e   state_r;
  uart_state_e   state_n_s;
  logic [BW-1:0] baud_r;
  logic [BW-1:0] baud_n_s;
  logic [2:0]    bit_r;
  logic [2:0]    bit_n_s;
  logic [7:0]    shift_r;
  logic [7:0]    shift_n_s;
  logic          bit_end_s;
  logic          pop_s;
  logic          tx_r;
  logic          active_r;
  logic          done_r;
  logic [7:0]    fifo_rd_data_s;
  logic          fifo_empty_s;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop_s),
    .rd_data  (fifo_rd_data_s),
    .full     (full),
    .empty    (fifo_empty_s),
    .count    (count),
    .overflow (overflow)
  );

  assign empty     = fifo_empty_s;
  assign tx        = tx_r;
  assign active    = active_r;
  assign done      = done_r;
  assign tx_state  = state_r;
  assign bit_end_s = (baud_r == BAUD_LAST);

  // Next-state, counters and shift register; the head byte is popped on entry to START.
  always_comb begin
    state_n_s = state_r;
    baud_n_s  = baud_r + BAUD_ONE;
    bit_n_s   = bit_r;
    shift_n_s = shift_r;
    pop_s     = 1'b0;
    case (state_r)
      UART_IDLE: begin
        baud_n_s = {BW{1'b0}};
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          state_n_s = UART_START;
          shift_n_s = fifo_rd_data_s;
          bit_n_s   = 3'd0;
        end else begin
          state_n_s = UART_IDLE;
        end
      end
      UART_START: begin
        if (bit_end_s) begin
          state_n_s = UART_DATA;
          baud_n_s  = {BW{1'b0}};
          bit_n_s   = 3'd0;
        end else begin
          state_n_s = UART_START;
        end
      end
      UART_DATA: begin
        if (bit_end_s) begin
          baud_n_s = {BW{1'b0}};
          if (bit_r == BIT_LAST) begin
            state_n_s = UART_STOP;
          end else begin
            bit_n_s   = bit_r + 3'd1;
            shift_n_s = {1'b0, shift_r[7:1]};
          end
        end else begin
          state_n_s = UART_DATA;
        end
      end
      UART_STOP: begin
        if (bit_end_s) begin
          baud_n_s = {BW{1'b0}};
          if (!fifo_empty_s) begin
            pop_s     = 1'b1;
            state_n_s = UART_START;
            shift_n_s = fifo_rd_data_s;
            bit_n_s   = 3'd0;
          end else begin
            state_n_s = UART_IDLE;
          end
        end else begin
          state_n_s = UART_STOP;
        end
      end
      default: begin
        state_n_s = UART_IDLE;
        baud_n_s  = {BW{1'b0}};
        bit_n_s   = 3'd0;
      end
    endcase
  end

  // State registers; line outputs are registered from the next state so they align with state_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= UART_IDLE;
      baud_r   <= {BW{1'b0}};
      bit_r    <= 3'd0;
      shift_r  <= 8'h00;
      tx_r     <= 1'b1;
      active_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      baud_r   <= baud_n_s;
      bit_r    <= bit_n_s;
      shift_r  <= shift_n_s;
      tx_r     <= uart_line_level(state_n_s, shift_n_s[0]);
      active_r <= (state_n_s != UART_IDLE);
      done_r   <= (state_n_s == UART_STOP) && (baud_n_s == BAUD_LAST);
    end
  end

endmodule
